alu_issue_arbiter: RTL and testbench

- Shares the single ALU (ADD/SUB/MUL, 2-bit alu_op) between two requesters, e.g. two issue slots.
- Accepts one operation at a time over a valid/ready handshake.
- Holds the operands and op stable on the ALU inputs for the full operation latency: 1 cycle for ADD/SUB, MUL_LATENCY cycles for MUL.
- Returns the captured result and zero flag, tagged with the requester id.

---
 rtl/alu_issue_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one ADD/SUB/MUL ALU between two requesters.
// One operation is in flight at a time. Operands and op are held on the ALU
// inputs for the whole operation latency (1 cycle, or MUL_LATENCY for MUL),
// then the result and zero flag are captured and returned tagged with the
// requester id as a one-cycle response pulse.
// Optional build macro ALU_ISSUE_ARBITER_FIXED_PRIO_EN: requester 0 always wins
// when both are valid (requester 1 can starve). Undefined: round-robin.
module alu_issue_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_first,
    input  logic [DATA_WIDTH-1:0] req0_second,
    input  logic [1:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_first,
    input  logic [DATA_WIDTH-1:0] req1_second,
    input  logic [1:0]            req1_op,
    output logic [DATA_WIDTH-1:0] alu_input_first,
    output logic [DATA_WIDTH-1:0] alu_input_second,
    output logic [1:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  resp_valid,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero
);

    localparam int         CNT_W  = $clog2(MUL_LATENCY + 1);
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic [DATA_WIDTH-1:0] alu_first_q, alu_first_d;
    logic [DATA_WIDTH-1:0] alu_second_q, alu_second_d;
    logic [1:0]            alu_op_q, alu_op_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
    logic                  resp_zero_q, resp_zero_d;

    logic                  can_grant;
    logic                  grant0;
    logic                  grant1;
    logic [1:0]            sel_op;

    // Arbitration: grants only in IDLE and never while reset is applied.
    always_comb begin
        can_grant = (state_q == IDLE) && !rst;
`ifdef ALU_ISSUE_ARBITER_FIXED_PRIO_EN
        grant0 = can_grant && req0_valid;
`else
        // With both valid, the requester that did not win last time goes next.
        grant0 = can_grant && req0_valid && (!req1_valid || last_grant_q);
`endif
        grant1 = can_grant && req1_valid && !grant0;
        sel_op = grant1 ? req1_op : req0_op;
    end

    // Next-state and datapath-capture logic for the IDLE/BUSY controller.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        count_d       = count_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        alu_first_d   = alu_first_q;
        alu_second_d  = alu_second_q;
        alu_op_d      = alu_op_q;
        resp_valid_d  = 1'b0;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    alu_first_d  = grant1 ? req1_first : req0_first;
                    alu_second_d = grant1 ? req1_second : req0_second;
                    alu_op_d     = sel_op;
                    count_d      = (sel_op == OP_MUL) ? CNT_W'(MUL_LATENCY) : CNT_W'(1);
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                count_d = count_q - CNT_W'(1);
                // Last cycle of the operation: the ALU output is now valid.
                if (count_q == CNT_W'(1)) begin
                    resp_valid_d  = 1'b1;
                    resp_id_d     = id_q;
                    resp_result_d = alu_result;
                    resp_zero_d   = alu_zero;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight operation and restores req0 priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            alu_first_q   <= '0;
            alu_second_q  <= '0;
            alu_op_q      <= 2'b00;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q       <= state_d;
            count_q       <= count_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            alu_first_q   <= alu_first_d;
            alu_second_q  <= alu_second_d;
            alu_op_q      <= alu_op_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

    assign req0_ready       = grant0;
    assign req1_ready       = grant1;
    assign alu_input_first  = alu_first_q;
    assign alu_input_second = alu_second_q;
    assign alu_op           = alu_op_q;
    assign resp_valid       = resp_valid_q;
    assign resp_id          = resp_id_q;
    assign resp_result      = resp_result_q;
    assign resp_zero        = resp_zero_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-timeline model
// of the arbiter. The ALU is a combinational behavioural stand-in.
module tb_alu_issue_arbiter;

    localparam int DW = 32;
    localparam int ML = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_first, req0_second, req1_first, req1_second;
    logic [1:0]    req0_op, req1_op;
    logic [DW-1:0] alu_input_first, alu_input_second, alu_result;
    logic [1:0]    alu_op;
    logic          alu_zero;
    logic          resp_valid, resp_id, resp_zero;
    logic [DW-1:0] resp_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.DATA_WIDTH(DW), .MUL_LATENCY(ML)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_first(req0_first),
        .req0_second(req0_second), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_first(req1_first),
        .req1_second(req1_second), .req1_op(req1_op),
        .alu_input_first(alu_input_first), .alu_input_second(alu_input_second),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
        .resp_zero(resp_zero)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_input_first, alu_input_second, alu_op);
    assign alu_zero   = (alu_result == '0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    typedef struct {
        logic          id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
    } txn_t;

    int unsigned   cyc = 0;
    bit            m_busy = 1'b0;
    int unsigned   m_done = 0;
    txn_t          m_cur;
    logic [DW-1:0] m_alu_a = '0, m_alu_b = '0;
    logic [1:0]    m_alu_op = 2'b00;
    logic          m_last = 1'b1;
    logic          m_resp_id = 1'b0, m_resp_zero = 1'b0;
    logic [DW-1:0] m_resp_res = '0;

    // Compare process: checks every DUT output each cycle, then advances the model.
    always @(negedge clk) begin
        bit e_r0, e_r1, e_rv, idle;
        cyc++;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        e_rv = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_alu_a = '0; m_alu_b = '0; m_alu_op = 2'b00;
            m_last = 1'b1; m_resp_id = 1'b0; m_resp_res = '0; m_resp_zero = 1'b0;
        end else begin
            if (m_busy && cyc == m_done) begin
                e_rv        = 1'b1;
                m_resp_id   = m_cur.id;
                m_resp_res  = alu_fn(m_cur.a, m_cur.b, m_cur.op);
                m_resp_zero = (m_resp_res == '0);
            end
            idle = !m_busy || cyc >= m_done;
            if (idle) begin
                if (req0_valid && req1_valid) begin
`ifdef ALU_ISSUE_ARBITER_FIXED_PRIO_EN
                    e_r0 = 1'b1;
`else
                    if (m_last) e_r0 = 1'b1;
                    else        e_r1 = 1'b1;
`endif
                end else begin
                    e_r0 = req0_valid;
                    e_r1 = req1_valid;
                end
            end
        end
        check("m_req0_ready", req0_ready, e_r0);
        check("m_req1_ready", req1_ready, e_r1);
        check("m_resp_valid", resp_valid, e_rv);
        check("m_resp_id", resp_id, m_resp_id);
        check("m_resp_result", resp_result, m_resp_res);
        check("m_resp_zero", resp_zero, m_resp_zero);
        check("m_alu_first", alu_input_first, m_alu_a);
        check("m_alu_second", alu_input_second, m_alu_b);
        check("m_alu_op", alu_op, m_alu_op);
        if (e_r0 || e_r1) begin
            m_cur.id = e_r1;
            m_cur.a  = e_r1 ? req1_first : req0_first;
            m_cur.b  = e_r1 ? req1_second : req0_second;
            m_cur.op = e_r1 ? req1_op : req0_op;
            m_busy   = 1'b1;
            m_done   = cyc + 1 + ((m_cur.op == 2'b10) ? ML : 1);
            m_alu_a  = m_cur.a;
            m_alu_b  = m_cur.b;
            m_alu_op = m_cur.op;
            m_last   = e_r1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int            grants[$];
        int            rids[$];
        logic [DW-1:0] rres[$];
        int            exp_g;

        rst = 1'b1;
        req0_valid = 1'b1; req0_first = '0; req0_second = '0; req0_op = 2'b00;
        req1_valid = 1'b1; req1_first = '0; req1_second = '0; req1_op = 2'b00;

        // Reset state: no ready even with both requesters valid.
        repeat (2) tick();
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_resp_result", resp_result, 0);

        // ADD from requester 0 only.
        tick();
        rst = 1'b0; req1_valid = 1'b0;
        req0_valid = 1'b1; req0_first = 'hE; req0_second = 'h9; req0_op = 2'b00;
        @(negedge clk);
        check("add_req0_ready", req0_ready, 1);
        check("add_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("add_no_resp_yet", resp_valid, 0);
        check("add_alu_first", alu_input_first, 'hE);
        tick();
        @(negedge clk);
        check("add_resp_valid", resp_valid, 1);
        check("add_resp_result", resp_result, 'h17);
        check("add_resp_zero", resp_zero, 0);
        check("add_resp_id", resp_id, 0);
        tick();
        @(negedge clk);
        check("add_pulse_once", resp_valid, 0);
        check("add_result_hold", resp_result, 'h17);

        // MUL from requester 1; both valid during BUSY must see no ready.
        tick();
        req1_valid = 1'b1; req1_first = 'hE; req1_second = 'h9; req1_op = 2'b10;
        @(negedge clk);
        check("mul_req1_ready", req1_ready, 1);
        check("mul_req0_ready", req0_ready, 0);
        tick();
        req0_valid = 1'b1;
        for (int k = 0; k < ML; k++) begin
            @(negedge clk);
            check("mul_busy_req0_ready", req0_ready, 0);
            check("mul_busy_req1_ready", req1_ready, 0);
            check("mul_busy_resp_valid", resp_valid, 0);
            check("mul_alu_first", alu_input_first, 'hE);
            check("mul_alu_second", alu_input_second, 'h9);
            check("mul_alu_op", alu_op, 2'b10);
            tick();
            if (k == ML - 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("mul_resp_valid", resp_valid, 1);
        check("mul_resp_result", resp_result, 'h7E);
        check("mul_resp_id", resp_id, 1);

        // Both valid continuously with ADDs: grant order and response order.
        tick();
        req0_valid = 1'b1; req0_first = 32'h7FFF_FFFF; req0_second = 32'h1; req0_op = 2'b00;
        req1_valid = 1'b1; req1_first = 32'h3; req1_second = 32'h4; req1_op = 2'b00;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (resp_valid) begin
                rids.push_back(int'(resp_id));
                rres.push_back(resp_result);
            end
            tick();
            if (i == 7) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        check("rr_grant_count", grants.size(), 4);
        check("rr_resp_count", rids.size(), 4);
        for (int i = 0; i < 4 && i < grants.size() && i < rids.size(); i++) begin
`ifdef ALU_ISSUE_ARBITER_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            check("rr_grant_order", grants[i], exp_g);
            check("rr_resp_id_order", rids[i], exp_g);
            check("rr_resp_result", rres[i], (exp_g == 1) ? 32'h7 : 32'h8000_0000);
        end

        // Back-to-back from requester 0: second grant in the first response cycle.
        req0_valid = 1'b1; req0_first = 32'h5; req0_second = 32'h3; req0_op = 2'b00;
        @(negedge clk);
        check("b2b_first_grant", req0_ready, 1);
        tick();
        req0_first = 32'h7; req0_second = 32'h7; req0_op = 2'b01;
        @(negedge clk);
        check("b2b_busy_ready", req0_ready, 0);
        tick();
        @(negedge clk);
        check("b2b_resp1_valid", resp_valid, 1);
        check("b2b_resp1_result", resp_result, 32'h8);
        check("b2b_second_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("b2b_gap", resp_valid, 0);
        tick();
        @(negedge clk);
        check("b2b_resp2_valid", resp_valid, 1);
        check("b2b_resp2_result", resp_result, 32'h0);
        check("b2b_resp2_zero", resp_zero, 1);

        // Reset two cycles into a MUL from requester 0.
        tick();
        req0_valid = 1'b1; req0_first = 32'h3; req0_second = 32'h3; req0_op = 2'b10;
        @(negedge clk);
        check("rstmul_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_first = 32'h20; req0_second = 32'h22; req0_op = 2'b00;
        req1_valid = 1'b1; req1_first = 32'h1; req1_second = 32'h1; req1_op = 2'b00;
        #1;
        check("rstmul_alu_op", alu_op, 0);
        check("rstmul_alu_first", alu_input_first, 0);
        check("rstmul_resp_zero", resp_zero, 0);
        check("rstmul_req0_ready", req0_ready, 0);
        check("rstmul_req1_ready", req1_ready, 0);
        @(negedge clk);
        check("rstmul_resp_valid_a", resp_valid, 0);
        tick();
        @(negedge clk);
        check("rstmul_resp_valid_b", resp_valid, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmul_after_req0", req0_ready, 1);
        check("rstmul_after_req1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("rstmul_dropped", resp_valid, 0);
        tick();
        @(negedge clk);
        check("rstmul_new_resp", resp_valid, 1);
        check("rstmul_new_id", resp_id, 0);
        check("rstmul_new_result", resp_result, 32'h42);

        // Reserved op 2'b11 from requester 1.
        tick();
        req1_valid = 1'b1; req1_first = 32'hF0; req1_second = 32'h0F; req1_op = 2'b11;
        @(negedge clk);
        check("op11_grant", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        check("op11_no_resp_yet", resp_valid, 0);
        check("op11_alu_op", alu_op, 2'b11);
        tick();
        req1_valid = 1'b1; req1_op = 2'b00;
        @(negedge clk);
        check("op11_resp_valid", resp_valid, 1);
        check("op11_resp_id", resp_id, 1);
        check("op11_resp_result", resp_result, 32'hFF);
        check("op11_back_idle", req1_ready, 1);
        tick();
        req1_valid = 1'b0;

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 249) == 0);
            req0_valid  = ($urandom_range(0, 9) < 6);
            req1_valid  = ($urandom_range(0, 9) < 6);
            req0_op     = 2'($urandom_range(0, 3));
            req1_op     = 2'($urandom_range(0, 3));
            req0_first  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            req1_first  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            req0_second = ($urandom_range(0, 3) == 0) ? req0_first : DW'($urandom_range(0, 7));
            req1_second = ($urandom_range(0, 3) == 0) ? req1_first : DW'($urandom);
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
